// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: vector defaults and
// the command set, whose enum order is the arbitration priority.
package pc_sequencer_pkg;

  localparam int unsigned DEF_RST_VECTOR = 0;
  localparam int unsigned DEF_INT_BASE   = 'h01;
  localparam int unsigned DEF_VEC_STRIDE = 2;

  // Earlier entries win when several commands arrive in one cycle.
  typedef enum logic [3:0] {
    CMD_NONE,
    CMD_INIT,
    CMD_INT,
    CMD_DBG,
    CMD_JUMP,
    CMD_CALL,
    CMD_RET,
    CMD_RETI,
    CMD_STEP
  } cmd_e;

  function automatic cmd_e cmd_decode(input logic init, input logic int_go,
                                      input logic dbg_wr, input logic jump,
                                      input logic call, input logic ret,
                                      input logic reti, input logic step);
    if (init)        return CMD_INIT;
    else if (int_go) return CMD_INT;
    else if (dbg_wr) return CMD_DBG;
    else if (jump)   return CMD_JUMP;
    else if (call)   return CMD_CALL;
    else if (ret)    return CMD_RET;
    else if (reti)   return CMD_RETI;
    else if (step)   return CMD_STEP;
    else             return CMD_NONE;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Command/status bundle between a sequencer controller (master) and the
// pc_sequencer core (slave).
interface pc_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int N_IRQ  = 4,
  parameter int LVL_W  = 4
);
  logic              init, step, jump, call, ret, reti;
  logic [ADDR_W-1:0] target;
  logic [N_IRQ-1:0]  irq, irq_mask;
  logic              ie_set, ie_clr;
  logic              int_req, int_ack;
  logic [2:0]        int_id;
  logic              dbg_halt, dbg_pc_wr;
  logic [ADDR_W-1:0] dbg_data;
  logic [ADDR_W-1:0] pc, ret_addr;
  logic              flag_ie, in_isr;
  logic [LVL_W-1:0]  stk_level;
  logic              stk_full, stk_empty, stk_ovf, stk_unf, err_clr;

  modport master (
    output init, step, jump, call, ret, reti, target, irq, irq_mask,
           ie_set, ie_clr, int_ack, dbg_halt, dbg_pc_wr, dbg_data, err_clr,
    input  int_req, int_id, pc, ret_addr, flag_ie, in_isr, stk_level,
           stk_full, stk_empty, stk_ovf, stk_unf
  );

  modport slave (
    input  init, step, jump, call, ret, reti, target, irq, irq_mask,
           ie_set, ie_clr, int_ack, dbg_halt, dbg_pc_wr, dbg_data, err_clr,
    output int_req, int_id, pc, ret_addr, flag_ie, in_isr, stk_level,
           stk_full, stk_empty, stk_ovf, stk_unf
  );
endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// LIFO return stack. Push when full and pop when empty are dropped here;
// the caller flags them as overflow/underflow.
module ret_stack #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic [WIDTH-1:0] top
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LVL_W-1:0] lvl_q;
  logic [PW-1:0]    wr_idx, top_idx;

  assign full    = (lvl_q == LVL_W'(DEPTH));
  assign empty   = (lvl_q == '0);
  assign level   = lvl_q;
  assign wr_idx  = lvl_q[PW-1:0];
  // Wraps to DEPTH-1 when full because the level MSB is dropped.
  assign top_idx = lvl_q[PW-1:0] - 1'b1;
  assign top     = mem[top_idx];

  // Storage is unreset; gating on rst_n keeps a reset edge from writing.
  always_ff @(posedge clk) begin
    if (rst_n && push && !full && !clr)
      mem[wr_idx] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  lvl_q <= '0;
    else if (clr)                lvl_q <= '0;
    else if (push && !full)      lvl_q <= lvl_q + 1'b1;
    else if (pop && !empty)      lvl_q <= lvl_q - 1'b1;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with return stack, interrupt entry/exit and debug PC
// write. One command per cycle, arbitrated by fixed priority.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter int          STK_DEPTH  = 8,
  parameter int          N_IRQ      = 4,
  parameter int unsigned RST_VECTOR = DEF_RST_VECTOR,
  parameter int unsigned INT_BASE   = DEF_INT_BASE,
  parameter int unsigned VEC_STRIDE = DEF_VEC_STRIDE
) (
  input logic          clk,
  input logic          rst_n,
  pc_sequencer_if.slave bus
);
  localparam int LVL_W = $clog2(STK_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RST_VECTOR);

  function automatic logic [2:0] lowest_idx(input logic [N_IRQ-1:0] v);
    logic [2:0] id;
    id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (v[i]) id = 3'(i);
    return id;
  endfunction

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ie_q, ie_d, isr_q, isr_d;
  logic [2:0]        id_q, id_d, sel_id;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic [N_IRQ-1:0]  pending;
  logic              int_req;
  logic [ADDR_W-1:0] vector;
  cmd_e              cmd;

  logic              stk_push, stk_pop, stk_clr, stk_full, stk_empty;
  logic [ADDR_W:0]   stk_top;
  logic [LVL_W-1:0]  stk_level;

  assign pending = bus.irq & bus.irq_mask;
  assign int_req = ie_q & ~bus.dbg_halt & ~isr_q & (|pending);
  assign sel_id  = lowest_idx(pending);
  assign vector  = ADDR_W'(INT_BASE + VEC_STRIDE * 32'(sel_id));

  assign cmd = cmd_decode(bus.init, bus.int_ack & int_req,
                          bus.dbg_halt & bus.dbg_pc_wr, bus.jump, bus.call,
                          bus.ret, bus.reti, bus.step);

  always_comb begin
    pc_d     = pc_q;
    isr_d    = isr_q;
    id_d     = id_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_clr  = 1'b0;
    ie_d     = ie_q;
    if (bus.ie_clr)      ie_d = 1'b0;
    else if (bus.ie_set) ie_d = 1'b1;

    unique case (cmd)
      CMD_INIT: begin
        pc_d    = RST_PC;
        ie_d    = 1'b0;
        isr_d   = 1'b0;
        id_d    = '0;
        stk_clr = 1'b1;
      end
      CMD_INT: begin
        stk_push = 1'b1;
        pc_d     = vector;
        id_d     = sel_id;
        ie_d     = 1'b0;
        isr_d    = 1'b1;
      end
      CMD_DBG:  pc_d = bus.dbg_data;
      CMD_JUMP: pc_d = bus.target;
      CMD_CALL: begin
        stk_push = 1'b1;
        pc_d     = bus.target;
      end
      CMD_RET: begin
        stk_pop = 1'b1;
        if (!stk_empty) pc_d = stk_top[ADDR_W-1:0];
      end
      CMD_RETI: begin
        stk_pop = 1'b1;
        if (!stk_empty) begin
          pc_d  = stk_top[ADDR_W-1:0];
          ie_d  = stk_top[ADDR_W];
          isr_d = 1'b0;
        end
      end
      CMD_STEP: pc_d = pc_q + 1'b1;
      default: ;
    endcase

    // A new error event outranks a same-cycle clear.
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (bus.err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (stk_push && stk_full) ovf_d = 1'b1;
    if (stk_pop && stk_empty) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RST_PC;
      ie_q  <= 1'b0;
      isr_q <= 1'b0;
      id_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ie_q  <= ie_d;
      isr_q <= isr_d;
      id_q  <= id_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  ret_stack #(
    .WIDTH (ADDR_W + 1),
    .DEPTH (STK_DEPTH),
    .LVL_W (LVL_W)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stk_clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   ({ie_q, pc_q}),
    .full  (stk_full),
    .empty (stk_empty),
    .level (stk_level),
    .top   (stk_top)
  );

  assign bus.pc        = pc_q;
  assign bus.ret_addr  = stk_top[ADDR_W-1:0];
  assign bus.flag_ie   = ie_q;
  assign bus.in_isr    = isr_q;
  assign bus.int_req   = int_req;
  assign bus.int_id    = id_q;
  assign bus.stk_level = stk_level;
  assign bus.stk_full  = stk_full;
  assign bus.stk_empty = stk_empty;
  assign bus.stk_ovf   = ovf_q;
  assign bus.stk_unf   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario bench for pc_sequencer: expected pc/stack level queued when a
// command is driven, popped and compared once the DUT has taken the edge.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(8), .N_IRQ(4), .LVL_W(4)) bus ();

  pc_sequencer #(
    .ADDR_W(8), .STK_DEPTH(8), .N_IRQ(4),
    .RST_VECTOR(0), .INT_BASE('h01), .VEC_STRIDE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [7:0] pc;
    logic [3:0] lvl;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  task automatic clear_cmds();
    bus.init = 0; bus.step = 0; bus.jump = 0; bus.call = 0;
    bus.ret = 0; bus.reti = 0; bus.ie_set = 0; bus.ie_clr = 0;
    bus.int_ack = 0; bus.dbg_pc_wr = 0; bus.err_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    total++; if (bus.pc !== 8'h00) begin bad++; $display("FAIL rst_pc got %h want 00", bus.pc); end
    total++; if (bus.stk_level !== 4'd0 || bus.stk_empty !== 1'b1 || bus.stk_full !== 1'b0) begin
      bad++; $display("FAIL rst_stack got lvl=%0d empty=%b full=%b want 0/1/0", bus.stk_level, bus.stk_empty, bus.stk_full); end
    total++; if ({bus.flag_ie, bus.in_isr, bus.int_id, bus.stk_ovf, bus.stk_unf, bus.int_req} !== 8'b0) begin
      bad++; $display("FAIL rst_flags got ie=%b isr=%b id=%0d ovf=%b unf=%b req=%b want all 0",
                      bus.flag_ie, bus.in_isr, bus.int_id, bus.stk_ovf, bus.stk_unf, bus.int_req); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.step = 1;
      sbq.push_back('{pc: 8'(i), lvl: 4'd0});
      tick();
      clear_cmds();
      e = sbq.pop_front();
      total++; if (bus.pc !== e.pc || bus.stk_level !== e.lvl) begin
        bad++; $display("FAIL step%0d got pc=%h lvl=%0d want pc=%h lvl=%0d", i, bus.pc, bus.stk_level, e.pc, e.lvl); end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      case (s)
        0: begin bus.dbg_halt = 1; bus.dbg_pc_wr = 1; bus.dbg_data = 8'hFF; sbq.push_back('{pc: 8'hFF, lvl: 4'd0}); end
        default: begin bus.step = 1; sbq.push_back('{pc: 8'h00, lvl: 4'd0}); end
      endcase
      tick();
      clear_cmds();
      e = sbq.pop_front();
      total++; if (bus.pc !== e.pc || bus.stk_level !== e.lvl) begin
        bad++; $display("FAIL wrap s%0d got pc=%h lvl=%0d want pc=%h lvl=%0d", s, bus.pc, bus.stk_level, e.pc, e.lvl); end
    end
    bus.dbg_halt = 0;
  endtask

  task automatic test_call_ret();
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin bus.jump = 1; bus.target = 8'h10; sbq.push_back('{pc: 8'h10, lvl: 4'd0}); end
        1: begin bus.call = 1; bus.target = 8'h40; sbq.push_back('{pc: 8'h40, lvl: 4'd1}); end
        default: begin bus.ret = 1; sbq.push_back('{pc: 8'h10, lvl: 4'd0}); end
      endcase
      tick();
      clear_cmds();
      e = sbq.pop_front();
      total++; if (bus.pc !== e.pc || bus.stk_level !== e.lvl) begin
        bad++; $display("FAIL call_ret s%0d got pc=%h lvl=%0d want pc=%h lvl=%0d", s, bus.pc, bus.stk_level, e.pc, e.lvl); end
      if (s == 1) begin
        total++; if (bus.ret_addr !== 8'h10) begin bad++; $display("FAIL call_top got %h want 10", bus.ret_addr); end
      end
    end
  endtask

  task automatic test_irq();
    exp_t e;
    bus.irq = 4'b1010; bus.irq_mask = 4'b1111;
    for (int s = 0; s < 8; s++) begin
      case (s)
        0: begin bus.ie_set = 1; bus.jump = 1; bus.target = 8'h22; sbq.push_back('{pc: 8'h22, lvl: 4'd0}); end
        1: begin bus.int_ack = 1; sbq.push_back('{pc: 8'h03, lvl: 4'd1}); end
        2: begin bus.reti = 1; sbq.push_back('{pc: 8'h22, lvl: 4'd0}); end
        3: begin bus.irq_mask = 4'b0101; bus.int_ack = 1; bus.step = 1; sbq.push_back('{pc: 8'h23, lvl: 4'd0}); end
        4: begin bus.irq_mask = 4'b1000; bus.int_ack = 1; sbq.push_back('{pc: 8'h07, lvl: 4'd1}); end
        5: begin bus.ret = 1; sbq.push_back('{pc: 8'h23, lvl: 4'd0}); end
        6: begin bus.init = 1; sbq.push_back('{pc: 8'h00, lvl: 4'd0}); end
        default: begin bus.ie_set = 1; bus.ie_clr = 1; bus.step = 1; sbq.push_back('{pc: 8'h01, lvl: 4'd0}); end
      endcase
      tick();
      clear_cmds();
      e = sbq.pop_front();
      total++; if (bus.pc !== e.pc || bus.stk_level !== e.lvl) begin
        bad++; $display("FAIL irq s%0d got pc=%h lvl=%0d want pc=%h lvl=%0d", s, bus.pc, bus.stk_level, e.pc, e.lvl); end
      case (s)
        0: begin total++; if (bus.flag_ie !== 1'b1 || bus.int_req !== 1'b1) begin
             bad++; $display("FAIL irq_pending got ie=%b req=%b want 1/1", bus.flag_ie, bus.int_req); end end
        1: begin total++; if ({bus.int_id, bus.flag_ie, bus.in_isr, bus.int_req} !== {3'd1, 1'b0, 1'b1, 1'b0}) begin
             bad++; $display("FAIL irq_entry got id=%0d ie=%b isr=%b req=%b want 1/0/1/0", bus.int_id, bus.flag_ie, bus.in_isr, bus.int_req); end end
        2: begin total++; if (bus.flag_ie !== 1'b1 || bus.in_isr !== 1'b0) begin
             bad++; $display("FAIL irq_reti got ie=%b isr=%b want 1/0", bus.flag_ie, bus.in_isr); end end
        4: begin total++; if (bus.int_id !== 3'd3 || bus.in_isr !== 1'b1) begin
             bad++; $display("FAIL irq_ch3 got id=%0d isr=%b want 3/1", bus.int_id, bus.in_isr); end end
        5: begin total++; if (bus.flag_ie !== 1'b0 || bus.in_isr !== 1'b1) begin
             bad++; $display("FAIL irq_plain_ret got ie=%b isr=%b want 0/1", bus.flag_ie, bus.in_isr); end end
        6: begin total++; if ({bus.flag_ie, bus.in_isr, bus.int_id} !== 5'b0) begin
             bad++; $display("FAIL irq_init got ie=%b isr=%b id=%0d want 0/0/0", bus.flag_ie, bus.in_isr, bus.int_id); end end
        7: begin total++; if (bus.flag_ie !== 1'b0) begin
             bad++; $display("FAIL ie_both got %b want 0", bus.flag_ie); end end
        default: ;
      endcase
    end
    bus.irq = 0; bus.irq_mask = 0;
  endtask

  task automatic test_overflow();
    exp_t e;
    bus.init = 1;
    tick();
    clear_cmds();
    for (int k = 0; k < 9; k++) begin
      bus.call = 1; bus.target = 8'h30 + 8'(k);
      sbq.push_back('{pc: 8'h30 + 8'(k), lvl: (k < 8) ? 4'(k + 1) : 4'd8});
      tick();
      clear_cmds();
      e = sbq.pop_front();
      total++; if (bus.pc !== e.pc || bus.stk_level !== e.lvl || bus.stk_ovf !== (k == 8)) begin
        bad++; $display("FAIL ovf_call%0d got pc=%h lvl=%0d ovf=%b want pc=%h lvl=%0d ovf=%b",
                        k, bus.pc, bus.stk_level, bus.stk_ovf, e.pc, e.lvl, k == 8); end
    end
    total++; if (bus.stk_full !== 1'b1) begin bad++; $display("FAIL ovf_full got %b want 1", bus.stk_full); end
    for (int r = 0; r < 9; r++) begin
      bus.ret = 1;
      sbq.push_back('{pc: (r < 7) ? 8'h36 - 8'(r) : 8'h00, lvl: (r < 8) ? 4'(7 - r) : 4'd0});
      tick();
      clear_cmds();
      e = sbq.pop_front();
      total++; if (bus.pc !== e.pc || bus.stk_level !== e.lvl || bus.stk_unf !== (r == 8)) begin
        bad++; $display("FAIL unf_ret%0d got pc=%h lvl=%0d unf=%b want pc=%h lvl=%0d unf=%b",
                        r, bus.pc, bus.stk_level, bus.stk_unf, e.pc, e.lvl, r == 8); end
    end
  endtask

  task automatic test_init_ack();
    exp_t e;
    bus.irq = 4'b0001; bus.irq_mask = 4'b0001;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin bus.ie_set = 1; bus.call = 1; bus.target = 8'h50; sbq.push_back('{pc: 8'h50, lvl: 4'd1}); end
        1: begin bus.init = 1; bus.int_ack = 1; sbq.push_back('{pc: 8'h00, lvl: 4'd0}); end
        2: begin bus.err_clr = 1; bus.ret = 1; sbq.push_back('{pc: 8'h00, lvl: 4'd0}); end
        default: begin bus.err_clr = 1; sbq.push_back('{pc: 8'h00, lvl: 4'd0}); end
      endcase
      tick();
      clear_cmds();
      e = sbq.pop_front();
      total++; if (bus.pc !== e.pc || bus.stk_level !== e.lvl) begin
        bad++; $display("FAIL init_ack s%0d got pc=%h lvl=%0d want pc=%h lvl=%0d", s, bus.pc, bus.stk_level, e.pc, e.lvl); end
      case (s)
        0: begin total++; if (bus.int_req !== 1'b1) begin bad++; $display("FAIL init_ack_req got %b want 1", bus.int_req); end end
        1: begin total++; if ({bus.in_isr, bus.flag_ie, bus.int_id, bus.stk_ovf, bus.stk_unf} !== 7'b0000011) begin
             bad++; $display("FAIL init_keep got isr=%b ie=%b id=%0d ovf=%b unf=%b want 0/0/0/1/1",
                             bus.in_isr, bus.flag_ie, bus.int_id, bus.stk_ovf, bus.stk_unf); end end
        2: begin total++; if (bus.stk_ovf !== 1'b0 || bus.stk_unf !== 1'b1) begin
             bad++; $display("FAIL err_set_wins got ovf=%b unf=%b want 0/1", bus.stk_ovf, bus.stk_unf); end end
        default: begin total++; if (bus.stk_unf !== 1'b0) begin
             bad++; $display("FAIL err_clr got unf=%b want 0", bus.stk_unf); end end
      endcase
    end
    bus.irq = 0; bus.irq_mask = 0;
  endtask

  task automatic test_dbg();
    exp_t e;
    bus.irq = 4'b0100; bus.irq_mask = 4'b1111;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin bus.ie_set = 1; sbq.push_back('{pc: 8'h00, lvl: 4'd0}); end
        1: begin bus.dbg_halt = 1; bus.dbg_pc_wr = 1; bus.dbg_data = 8'h55; bus.int_ack = 1;
                 sbq.push_back('{pc: 8'h55, lvl: 4'd0}); end
        default: begin bus.dbg_halt = 0; bus.dbg_pc_wr = 1; bus.dbg_data = 8'hAA; sbq.push_back('{pc: 8'h55, lvl: 4'd0}); end
      endcase
      if (s == 1) begin
        #1;
        total++; if (bus.int_req !== 1'b0) begin bad++; $display("FAIL dbg_block got req=%b want 0", bus.int_req); end
      end
      tick();
      clear_cmds();
      e = sbq.pop_front();
      total++; if (bus.pc !== e.pc || bus.stk_level !== e.lvl || bus.in_isr !== 1'b0) begin
        bad++; $display("FAIL dbg s%0d got pc=%h lvl=%0d isr=%b want pc=%h lvl=%0d isr=0", s, bus.pc, bus.stk_level, bus.in_isr, e.pc, e.lvl); end
      if (s != 1) begin
        total++; if (bus.int_req !== 1'b1) begin bad++; $display("FAIL dbg_req s%0d got %b want 1", s, bus.int_req); end
      end
    end
    bus.irq = 0; bus.irq_mask = 0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin bus.jump = 1; bus.ret = 1; bus.step = 1; bus.target = 8'h60; sbq.push_back('{pc: 8'h60, lvl: 4'd0}); end
        1: begin bus.call = 1; bus.step = 1; bus.target = 8'h70; sbq.push_back('{pc: 8'h70, lvl: 4'd1}); end
        2: begin bus.ret = 1; bus.step = 1; sbq.push_back('{pc: 8'h60, lvl: 4'd0}); end
        default: begin bus.step = 1; sbq.push_back('{pc: 8'h61, lvl: 4'd0}); end
      endcase
      tick();
      clear_cmds();
      e = sbq.pop_front();
      total++; if (bus.pc !== e.pc || bus.stk_level !== e.lvl) begin
        bad++; $display("FAIL b2b s%0d got pc=%h lvl=%0d want pc=%h lvl=%0d", s, bus.pc, bus.stk_level, e.pc, e.lvl); end
    end
  endtask

  initial begin
    clear_cmds();
    bus.target = 0; bus.irq = 0; bus.irq_mask = 0;
    bus.dbg_halt = 0; bus.dbg_data = 0;
    #12;
    test_reset();
    test_wrap();
    test_call_ret();
    test_irq();
    test_overflow();
    test_init_ack();
    test_dbg();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
